// File: rtl/add_sub_pkg.sv
// Shared types and constants for the multi-precision add/sub datapath.
// Holds the controller state encoding, the mode encodings and the default slice width.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int DEFAULT_SLICE = 4;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational SLICE-bit ripple add/sub slice. Subtraction inverts b and relies on the
// caller to supply cin=1 on the first slice; c_msb_in feeds the signed-overflow check.
module add_sub_slice
    import add_sub_pkg::*;
#(
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE-1:0] bx_s;

    assign bx_s = b ^ {SLICE{mode}};

    // Ripple carry chain across the slice bits
    always_comb begin
        logic [SLICE:0] c_v;
        c_v      = '0;
        sum      = '0;
        c_v[0]   = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ bx_s[i] ^ c_v[i];
            c_v[i+1] = (a[i] & bx_s[i]) | (a[i] & c_v[i]) | (bx_s[i] & c_v[i]);
        end
        cout     = c_v[SLICE];
        c_msb_in = c_v[SLICE-1];
    end

endmodule

// File: rtl/multiword_add_sub.sv
// Sequential multi-precision adder/subtractor: processes one SLICE-bit chunk per cycle,
// LSB first, keeping the ripple carry in a register between cycles.
module multiword_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic               mode_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [SLICE-1:0]   sum_s;
    logic               cout_s;
    logic               c_msb_in_s;
    logic               last_s;

    assign last_s = (idx_r == IDX_W'(N - 1));

    add_sub_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_r[idx_r*SLICE +: SLICE]),
        .b        (b_r[idx_r*SLICE +: SLICE]),
        .mode     (mode_r),
        .cin      (carry_r),
        .sum      (sum_s),
        .cout     (cout_s),
        .c_msb_in (c_msb_in_s)
    );

    // Next-state logic for the IDLE -> RUN -> DONE sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            idx_r     <= '0;
            carry_r   <= 1'b0;
            mode_r    <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            state_r <= state_next_s;
            // busy/done are decoded from the next state so they line up with the state register
            busy    <= (state_next_s != IDLE);
            done    <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        mode_r  <= mode;
                        idx_r   <= '0;
                        carry_r <= mode;
                    end
                end
                RUN: begin
                    result[idx_r*SLICE +: SLICE] <= sum_s;
                    carry_r <= cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        carry_out <= cout_s;
                        overflow  <= cout_s ^ c_msb_in_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
